// File: rtl/rezhim_pkg.sv
// Shared types, codes and helpers for the display-mode / time-setup controller.
// Imported by rezhim_ctrl and its idle timeout sub-module.
package rezhim_pkg;

    typedef enum logic [2:0] {
        ST_CLOCK = 3'd0,
        ST_TIMER = 3'd1,
        ST_STOPW = 3'd2,
        ST_SET_H = 3'd3,
        ST_SET_M = 3'd4,
        ST_SET_S = 3'd5
    } state_t;

    localparam logic [1:0] REZHIM_CLOCK = 2'd0;
    localparam logic [1:0] REZHIM_TIMER = 2'd1;
    localparam logic [1:0] REZHIM_STOPW = 2'd2;
    localparam logic [1:0] REZHIM_SETUP = 2'd3;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [7:0] HOUR_MAX   = 8'd23;
    localparam logic [7:0] MINSEC_MAX = 8'd59;

    // Out-of-range captures (e.g. a corrupt hour of 30) also fold back to zero.
    function automatic logic [7:0] inc_wrap(input logic [7:0] value, input logic [7:0] limit);
        logic [7:0] result;
        if (value >= limit) begin
            result = 8'd0;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    function automatic logic is_setup(input state_t st);
        logic result;
        case (st)
            ST_SET_H, ST_SET_M, ST_SET_S: result = 1'b1;
            default:                      result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/rezhim_ctrl_idle_timer.sv
// Seconds-based idle counter for the setup screens; flags expiry on the tick
// that would bring the count to TIMEOUT_S, unless a clear arrives that cycle.
module idle_timer #(
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expired
);
    import rezhim_pkg::*;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_S - 1);

    logic [7:0] count_r;
    logic       hit_s;

    // Expiry decode; a simultaneous clear (button press) always wins.
    always_comb begin
        hit_s = 1'b0;
        if (enable && tick && !clear && (count_r == LAST_COUNT)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    assign expired = hit_s;

    // Idle second counter; restarts after expiry so the next setup starts fresh.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= 8'd0;
        end else if (clear || hit_s) begin
            count_r <= 8'd0;
        end else if (enable && tick) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/rezhim_ctrl.sv
// Display-mode controller: cycles clock/timer/stopwatch views and runs the
// hour/min/sec setup editor that hands a new time to the clock core.
module rezhim_ctrl #(
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        tick_1hz,
    input  logic [23:0] data_ch,
    output logic [1:0]  rezhim,
    output logic [1:0]  setup_field,
    output logic [23:0] setup_data,
    output logic        setup_load
);
    import rezhim_pkg::*;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  rezhim_s;
    logic [1:0]  field_s;
    logic [23:0] data_s;
    logic        load_s;
    logic        any_btn_s;
    logic        expired_s;

    assign any_btn_s = btn_mode | btn_sel | btn_inc;

    idle_timer #(
        .TIMEOUT_S(TIMEOUT_S)
    ) u_idle_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (any_btn_s),
        .enable  (is_setup(state_r)),
        .tick    (tick_1hz),
        .expired (expired_s)
    );

    // Next state and edited data; button priority is mode > sel > inc > timeout.
    always_comb begin
        state_s = state_r;
        data_s  = setup_data;
        load_s  = 1'b0;
        case (state_r)
            ST_CLOCK: begin
                if (btn_mode) begin
                    state_s = ST_TIMER;
                end else if (btn_sel) begin
                    state_s = ST_SET_H;
                    data_s  = data_ch;
                end else begin
                    state_s = ST_CLOCK;
                end
            end
            ST_TIMER: begin
                if (btn_mode) begin
                    state_s = ST_STOPW;
                end else begin
                    state_s = ST_TIMER;
                end
            end
            ST_STOPW: begin
                if (btn_mode) begin
                    state_s = ST_CLOCK;
                end else begin
                    state_s = ST_STOPW;
                end
            end
            ST_SET_H, ST_SET_M, ST_SET_S: begin
                if (btn_mode) begin
                    state_s = ST_CLOCK;
                    load_s  = 1'b1;
                end else if (btn_sel) begin
                    case (state_r)
                        ST_SET_H: state_s = ST_SET_M;
                        ST_SET_M: state_s = ST_SET_S;
                        default:  state_s = ST_SET_H;
                    endcase
                end else if (btn_inc) begin
                    case (state_r)
                        ST_SET_H: data_s = {inc_wrap(setup_data[23:16], HOUR_MAX), setup_data[15:0]};
                        ST_SET_M: data_s = {setup_data[23:16], inc_wrap(setup_data[15:8], MINSEC_MAX),
                                            setup_data[7:0]};
                        default:  data_s = {setup_data[23:8], inc_wrap(setup_data[7:0], MINSEC_MAX)};
                    endcase
                end else if (expired_s) begin
                    state_s = ST_CLOCK;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_CLOCK;
            end
        endcase
    end

    // Output codes follow the state being entered so they register alongside it.
    always_comb begin
        rezhim_s = REZHIM_CLOCK;
        field_s  = FIELD_NONE;
        case (state_s)
            ST_CLOCK: begin rezhim_s = REZHIM_CLOCK; field_s = FIELD_NONE; end
            ST_TIMER: begin rezhim_s = REZHIM_TIMER; field_s = FIELD_NONE; end
            ST_STOPW: begin rezhim_s = REZHIM_STOPW; field_s = FIELD_NONE; end
            ST_SET_H: begin rezhim_s = REZHIM_SETUP; field_s = FIELD_HOUR; end
            ST_SET_M: begin rezhim_s = REZHIM_SETUP; field_s = FIELD_MIN;  end
            ST_SET_S: begin rezhim_s = REZHIM_SETUP; field_s = FIELD_SEC;  end
            default:  begin rezhim_s = REZHIM_CLOCK; field_s = FIELD_NONE; end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_CLOCK;
            rezhim      <= REZHIM_CLOCK;
            setup_field <= FIELD_NONE;
            setup_data  <= 24'd0;
            setup_load  <= 1'b0;
        end else begin
            state_r     <= state_s;
            rezhim      <= rezhim_s;
            setup_field <= field_s;
            setup_data  <= data_s;
            setup_load  <= load_s;
        end
    end

endmodule
